// File: rtl/kamikaze_imem_bridge_if.sv
// Pipelined request/grant/response instruction-bus bundle between the fetch
// bridge (master) and instruction memory (slave).
interface kamikaze_imem_bridge_if;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o,
        output bus_addr_o,
        input  bus_gnt_i,
        input  bus_rvalid_i,
        input  bus_rdata_i,
        input  bus_err_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_addr_o,
        output bus_gnt_i,
        output bus_rvalid_i,
        output bus_rdata_i,
        output bus_err_i
    );
endinterface

// File: rtl/kamikaze_imem_bridge.sv
// Sequential instruction fetch bridge with credit-limited outstanding requests,
// response buffer and branch flush. Optional error tagging: KMKZ_IMEM_ERR_EN.
module kamikaze_imem_bridge #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    kamikaze_imem_bridge_if.master        bus,
    input  logic                          branch_i,
    input  logic [31:0]                   pc_set_i,
    output logic [31:0]                   ir_o,
    output logic                          memory_ready_o,
    input  logic                          fetch_ready_i,
    output logic                          fault_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
    localparam logic [31:0]   NOP_WORD   = 32'h0000_0013;
    localparam logic [31:0]   RESET_ADDR = {PC_RESET[31:2], 2'b00};

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [31:0]     req_addr_r, req_addr_nx_s;
    logic [CW-1:0]   outstanding_r, outstanding_nx_s;
    logic [CW-1:0]   buf_count_r, buf_count_nx_s;
    logic [CW-1:0]   stale_cnt_r, stale_cnt_nx_s;
    logic [PW-1:0]   wr_ptr_r, wr_ptr_nx_s;
    logic [PW-1:0]   rd_ptr_r, rd_ptr_nx_s;
    logic [31:0]     mem_r [DEPTH];
    logic [CW-1:0]   credit_s;
    logic            req_s, gnt_s, rsp_s, write_s, pop_s;
    logic [31:0]     store_word_s;

`ifdef KMKZ_IMEM_ERR_EN
    logic            err_r [DEPTH];

    // An errored response is delivered as an all-zero (illegal) instruction.
    function automatic logic [31:0] sanitize_word(input logic [31:0] data, input logic err);
        logic [31:0] word;
        if (err) begin
            word = 32'h0000_0000;
        end else begin
            word = data;
        end
        return word;
    endfunction

    // Word and its error tag leave the buffer together.
    always_comb begin
        store_word_s = sanitize_word(bus.bus_rdata_i, bus.bus_err_i);
        fault_o      = err_r[rd_ptr_r];
    end
`else
    // Without error tagging the raw data passes through.
    always_comb begin
        store_word_s = bus.bus_rdata_i;
        fault_o      = 1'b0;
    end
`endif

    // Credit, bus handshake and buffer qualifiers.
    always_comb begin
        credit_s       = DEPTH_C - outstanding_r - buf_count_r;
        memory_ready_o = (buf_count_r != CNT_ZERO);
        req_s          = (state_r != BOOT) && (credit_s != CNT_ZERO) && !branch_i;
        gnt_s          = req_s && bus.bus_gnt_i;
        rsp_s          = bus.bus_rvalid_i;
        write_s        = rsp_s && (stale_cnt_r == CNT_ZERO) && !branch_i;
        pop_s          = fetch_ready_i && memory_ready_o && !branch_i;
        bus.bus_req_o  = req_s;
        bus.bus_addr_o = req_addr_r;
        ir_o           = mem_r[rd_ptr_r];
    end

    // Next-state logic for the BOOT/RUN/STALL sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            BOOT: begin
                if (branch_i) begin
                    state_nx_s = BOOT;
                end else begin
                    state_nx_s = RUN;
                end
            end
            RUN: begin
                if (credit_s == CNT_ZERO) begin
                    state_nx_s = STALL;
                end else begin
                    state_nx_s = RUN;
                end
            end
            STALL: begin
                if (credit_s != CNT_ZERO) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = STALL;
                end
            end
            default: state_nx_s = BOOT;
        endcase
    end

    // Counter and pointer updates; a redirect overrides everything but the in-flight count.
    always_comb begin
        outstanding_nx_s = outstanding_r + CW'(gnt_s) - CW'(rsp_s);
        req_addr_nx_s    = req_addr_r;
        stale_cnt_nx_s   = stale_cnt_r;
        buf_count_nx_s   = buf_count_r;
        wr_ptr_nx_s      = wr_ptr_r;
        rd_ptr_nx_s      = rd_ptr_r;
        if (branch_i) begin
            req_addr_nx_s  = {pc_set_i[31:2], 2'b00};
            stale_cnt_nx_s = outstanding_r - CW'(rsp_s);
            buf_count_nx_s = CNT_ZERO;
            wr_ptr_nx_s    = PTR_ZERO;
            rd_ptr_nx_s    = PTR_ZERO;
        end else begin
            if (gnt_s) begin
                req_addr_nx_s = req_addr_r + 32'd4;
            end else begin
                req_addr_nx_s = req_addr_r;
            end
            if (rsp_s && (stale_cnt_r != CNT_ZERO)) begin
                stale_cnt_nx_s = stale_cnt_r - CW'(1);
            end else begin
                stale_cnt_nx_s = stale_cnt_r;
            end
            if (write_s) begin
                wr_ptr_nx_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            buf_count_nx_s = buf_count_r + CW'(write_s) - CW'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= BOOT;
            req_addr_r    <= RESET_ADDR;
            outstanding_r <= CNT_ZERO;
            buf_count_r   <= CNT_ZERO;
            stale_cnt_r   <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
        end else begin
            state_r       <= state_nx_s;
            req_addr_r    <= req_addr_nx_s;
            outstanding_r <= outstanding_nx_s;
            buf_count_r   <= buf_count_nx_s;
            stale_cnt_r   <= stale_cnt_nx_s;
            wr_ptr_r      <= wr_ptr_nx_s;
            rd_ptr_r      <= rd_ptr_nx_s;
        end
    end

    // Response buffer storage; entries reset to NOP so an idle head reads as NOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= NOP_WORD;
`ifdef KMKZ_IMEM_ERR_EN
                err_r[i] <= 1'b0;
`endif
            end
        end else if (write_s) begin
            mem_r[wr_ptr_r] <= store_word_s;
`ifdef KMKZ_IMEM_ERR_EN
            err_r[wr_ptr_r] <= bus.bus_err_i;
`endif
        end
    end

endmodule

// File: tb/tb_kamikaze_imem_bridge.sv
// Directed, table-driven bench for kamikaze_imem_bridge (DEPTH=2, PC_RESET=0x100)
// plus a second instance checking the address wrap from 0xFFFF_FFF8.
module tb_kamikaze_imem_bridge;

`ifdef KMKZ_IMEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, fetch_ready, w_branch, w_fetch_ready;
    logic [31:0] pc_set, w_pc_set;
    logic [31:0] ir, w_ir;
    logic        mready, fault, w_mready, w_fault;

    int n_tests = 0;
    int n_fail  = 0;

    kamikaze_imem_bridge_if bif ();
    kamikaze_imem_bridge_if wif ();

    kamikaze_imem_bridge #(.DEPTH(2), .PC_RESET(32'h0000_0100)) u_dut (
        .clk_i(clk), .rst_i(rst), .bus(bif.master),
        .branch_i(branch), .pc_set_i(pc_set), .ir_o(ir),
        .memory_ready_o(mready), .fetch_ready_i(fetch_ready), .fault_o(fault)
    );

    kamikaze_imem_bridge #(.DEPTH(2), .PC_RESET(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst), .bus(wif.master),
        .branch_i(w_branch), .pc_set_i(w_pc_set), .ir_o(w_ir),
        .memory_ready_o(w_mready), .fetch_ready_i(w_fetch_ready), .fault_o(w_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        br;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic        fr;
        logic        req;
        logic [31:0] addr;
        logic        mr;
        logic        ck;
        logic [31:0] ir;
        logic        flt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];
    logic [31:0] wrap_addr [4];
    logic        wrap_req  [4];

    function automatic vec_t mk(input logic br, input logic [31:0] pc, input logic gnt,
                                input logic rv, input logic [31:0] rd, input logic err,
                                input logic fr, input logic req, input logic [31:0] addr,
                                input logic mr, input logic ck, input logic [31:0] irv,
                                input logic flt);
        vec_t v;
        v.br = br; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err; v.fr = fr;
        v.req = req; v.addr = addr; v.mr = mr; v.ck = ck; v.ir = irv; v.flt = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    int reqs;

    initial begin
        // br pc gnt rv rdata err fr | req addr mr ck ir flt
        vecs[0]  = mk(0, 0, 1, 0, 0,             0, 1, 0, 32'h100, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h100, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 32'hC0DE_0100, 0, 1, 1, 32'h104, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 32'hC0DE_0104, 0, 1, 0, 32'h108, 1, 1, 32'hC0DE_0100, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h108, 1, 1, 32'hC0DE_0104, 0);
        vecs[5]  = mk(0, 0, 1, 1, 32'hC0DE_0108, 0, 1, 1, 32'h10C, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 1, 32'hC0DE_010C, 0, 1, 0, 32'h110, 1, 1, 32'hC0DE_0108, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0,             0, 0, 1, 32'h110, 1, 1, 32'hC0DE_010C, 0);
        vecs[8]  = mk(0, 0, 1, 1, 32'hC0DE_0110, 0, 0, 0, 32'h114, 1, 1, 32'hC0DE_010C, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0,             0, 0, 0, 32'h114, 1, 1, 32'hC0DE_010C, 0);
        vecs[10] = mk(0, 0, 1, 0, 0,             0, 1, 0, 32'h114, 1, 1, 32'hC0DE_010C, 0);
        vecs[11] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h114, 1, 1, 32'hC0DE_0110, 0);
        vecs[12] = mk(0, 0, 0, 1, 32'hC0DE_0114, 0, 1, 1, 32'h118, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0,             0, 1, 1, 32'h118, 1, 1, 32'hC0DE_0114, 0);
        vecs[14] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h118, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h11C, 0, 0, 0, 0);
        vecs[16] = mk(1, 32'h2002, 1, 0, 0,      0, 1, 0, 32'h120, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 1, 32'hC0DE_0118, 0, 1, 0, 32'h2000, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 32'hC0DE_011C, 0, 1, 1, 32'h2000, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h2000, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 32'hBEEF_2000, 0, 1, 1, 32'h2004, 0, 0, 0, 0);
        vecs[21] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h2004, 1, 1, 32'hBEEF_2000, 0);
        vecs[22] = mk(0, 0, 1, 1, 32'hBEEF_2004, 0, 1, 1, 32'h2008, 0, 0, 0, 0);
        vecs[23] = mk(1, 32'h3000, 1, 1, 32'hBEEF_2008, 0, 1, 0, 32'h200C, 1, 1, 32'hBEEF_2004, 0);
        vecs[24] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h3000, 0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0, 1, 32'hBEEF_3000, 0, 1, 1, 32'h3004, 0, 0, 0, 0);
        vecs[26] = mk(0, 0, 1, 0, 0,             0, 1, 1, 32'h3004, 1, 1, 32'hBEEF_3000, 0);
        vecs[27] = mk(0, 0, 1, 1, 32'hBAD0_3004, 1, 1, 1, 32'h3008, 0, 0, 0, 0);
        vecs[28] = mk(0, 0, 1, 1, 32'hBEEF_3008, 0, 1, 0, 32'h300C, 1, 1,
                      ERR_EN ? 32'h0000_0000 : 32'hBAD0_3004, ERR_EN);
        vecs[29] = mk(0, 0, 0, 0, 0,             0, 1, 1, 32'h300C, 1, 1, 32'hBEEF_3008, 0);

        wrap_addr[0] = 32'hFFFF_FFF8; wrap_req[0] = 1'b0;
        wrap_addr[1] = 32'hFFFF_FFF8; wrap_req[1] = 1'b1;
        wrap_addr[2] = 32'hFFFF_FFFC; wrap_req[2] = 1'b1;
        wrap_addr[3] = 32'h0000_0000; wrap_req[3] = 1'b0;

        rst = 1'b1;
        branch = 1'b0; pc_set = 32'h0; fetch_ready = 1'b0;
        bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_rdata_i = 32'h0; bif.bus_err_i = 1'b0;
        w_branch = 1'b0; w_pc_set = 32'h0; w_fetch_ready = 1'b0;
        wif.bus_gnt_i = 1'b1; wif.bus_rvalid_i = 1'b0; wif.bus_rdata_i = 32'h0; wif.bus_err_i = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset req",   32'(bif.bus_req_o), 32'd0);
        chk("reset addr",  bif.bus_addr_o, 32'h0000_0100);
        chk("reset ready", 32'(mready), 32'd0);
        chk("reset ir",    ir, 32'h0000_0013);
        chk("reset fault", 32'(fault), 32'd0);
        chk("wrap reset addr", wif.bus_addr_o, 32'hFFFF_FFF8);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            branch = vecs[i].br; pc_set = vecs[i].pc; fetch_ready = vecs[i].fr;
            bif.bus_gnt_i = vecs[i].gnt; bif.bus_rvalid_i = vecs[i].rv;
            bif.bus_rdata_i = vecs[i].rd; bif.bus_err_i = vecs[i].err;
            #1;
            chk($sformatf("row%0d req", i),   32'(bif.bus_req_o), 32'(vecs[i].req));
            chk($sformatf("row%0d addr", i),  bif.bus_addr_o, vecs[i].addr);
            chk($sformatf("row%0d ready", i), 32'(mready), 32'(vecs[i].mr));
            if (vecs[i].ck) begin
                chk($sformatf("row%0d ir", i),    ir, vecs[i].ir);
                chk($sformatf("row%0d fault", i), 32'(fault), 32'(vecs[i].flt));
            end
            if (i < 4) begin
                chk($sformatf("wrap%0d addr", i), wif.bus_addr_o, wrap_addr[i]);
                chk($sformatf("wrap%0d req", i),  32'(wif.bus_req_o), 32'(wrap_req[i]));
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle.
        branch = 1'b0; fetch_ready = 1'b0;
        bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_err_i = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst req",   32'(bif.bus_req_o), 32'd0);
        chk("midrst addr",  bif.bus_addr_o, 32'h0000_0100);
        chk("midrst ready", 32'(mready), 32'd0);
        chk("midrst ir",    ir, 32'h0000_0013);
        chk("midrst fault", 32'(fault), 32'd0);

        // Backpressure from empty: exactly DEPTH requests, then stall, then resume.
        @(negedge clk);
        rst = 1'b0; bif.bus_gnt_i = 1'b1;
        #1;
        chk("bp boot req", 32'(bif.bus_req_o), 32'd0);
        reqs = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bif.bus_rvalid_i = (k == 2) || (k == 3);
            bif.bus_rdata_i  = (k == 2) ? 32'hC0DE_0100 : 32'hC0DE_0104;
            #1;
            if (bif.bus_req_o) reqs++;
        end
        chk("bp request count", 32'(reqs), 32'd2);
        chk("bp stall req",  32'(bif.bus_req_o), 32'd0);
        chk("bp stall addr", bif.bus_addr_o, 32'h0000_0108);
        chk("bp stall ir",   ir, 32'hC0DE_0100);
        @(negedge clk);
        bif.bus_rvalid_i = 1'b0; fetch_ready = 1'b1;
        #1;
        chk("bp pop1 ready", 32'(mready), 32'd1);
        chk("bp pop1 ir",    ir, 32'hC0DE_0100);
        chk("bp pop1 req",   32'(bif.bus_req_o), 32'd0);
        @(negedge clk);
        #1;
        chk("bp pop2 ir",    ir, 32'hC0DE_0104);
        chk("bp resume req", 32'(bif.bus_req_o), 32'd1);
        chk("bp resume addr", bif.bus_addr_o, 32'h0000_0108);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
